// File: rtl/core_ctrl_endpoint.sv
// rtl/core_ctrl_endpoint.sv - core-side control endpoint to the load balancer
// Optional CTRL_STATS_EN adds tx_msg_count / rx_msg_count message counters.
module core_ctrl_endpoint #(
  parameter int CTRL_WIDTH    = 36,
  parameter int SLOT_COUNT    = 32,
  parameter int SLOT_WIDTH    = $clog2(SLOT_COUNT + 1),
  parameter int CORE_ID_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [CTRL_WIDTH-1:0] ctrl_m_axis_tdata,
  output logic                  ctrl_m_axis_tvalid,
  input  logic                  ctrl_m_axis_tready,
  input  logic [CTRL_WIDTH-1:0] ctrl_s_axis_tdata,
  input  logic                  ctrl_s_axis_tvalid,
  output logic                  ctrl_s_axis_tready,
  input  logic                  init_req,
  input  logic [SLOT_WIDTH-1:0] init_slots,
  input  logic [SLOT_WIDTH-1:0] slot_free_data,
  input  logic                  slot_free_valid,
  output logic                  slot_free_ready,
  input  logic [31:0]           done_desc,
  input  logic                  done_valid,
  output logic                  done_ready,
  input  logic [31:0]           fwd_desc,
  input  logic                  fwd_valid,
  output logic                  fwd_ready,
  output logic [31:0]           rx_desc,
  output logic                  rx_type,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [SLOT_WIDTH-1:0] outstanding_done,
  output logic                  ctrl_err
`ifdef CTRL_STATS_EN
  ,
  output logic [31:0]           tx_msg_count,
  output logic [31:0]           rx_msg_count
`endif
);

  typedef enum logic [1:0] {RESET_WAIT, SEND_INIT, RUN} state_t;

  state_t                r_state;
  logic [1:0]            r_ptr;
  logic [CTRL_WIDTH-1:0] r_tdata;
  logic                  r_tvalid;
  logic [SLOT_WIDTH-1:0] r_outstanding;
  logic                  r_err;
  logic [32:0]           r_skid [2];
  logic                  r_rd;
  logic [1:0]            r_cnt;

  logic                  w_load, w_full, w_run, w_any, w_grant_ok, w_src_acc, w_init_offer;
  logic [3:0]            w_req;
  logic [1:0]            w_sel, w_idx;
  logic [31:0]           w_slot_desc, w_init_desc, w_fwd_desc;
  logic [CTRL_WIDTH-1:0] w_msg;
  logic [3:0]            w_in_type;
  logic                  w_in_acc, w_push, w_pop, w_inc, w_dec;

  function automatic logic [CTRL_WIDTH-1:0] f_msg(input logic [3:0] t, input logic [31:0] d);
    return CTRL_WIDTH'({t, d});
  endfunction

  assign w_load       = !r_tvalid || ctrl_m_axis_tready;
  assign w_full       = (r_outstanding == SLOT_WIDTH'(SLOT_COUNT));
  assign w_run        = (r_state == RUN) && !init_req;
  assign w_init_offer = (r_state == SEND_INIT) && !init_req;
  assign w_req        = {1'b0, fwd_valid, done_valid && !w_full, slot_free_valid};

  // Round-robin: scan from the pointer; the lowest offset found last wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_ptr;
    w_idx = r_ptr;
    for (int i = 2; i >= 0; i--) begin
      w_idx = 2'((int'(r_ptr) + i) % 3);
      if (w_req[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_grant_ok      = w_any && w_run;
  assign w_src_acc       = w_grant_ok && w_load;
  assign slot_free_ready = w_src_acc && (w_sel == 2'd0);
  assign done_ready      = w_src_acc && (w_sel == 2'd1);
  assign fwd_ready       = w_src_acc && (w_sel == 2'd2);

  // Destination-core field is forwarded in place with the rest of the descriptor.
  assign w_fwd_desc = {fwd_desc[31:24+CORE_ID_WIDTH], fwd_desc[24+:CORE_ID_WIDTH], fwd_desc[23:0]};

  always_comb begin
    w_slot_desc = '0;
    w_slot_desc[16+:SLOT_WIDTH] = slot_free_data;
    w_init_desc = '0;
    w_init_desc[16+:SLOT_WIDTH] = init_slots;
    w_msg = '0;
    if (r_state == SEND_INIT) w_msg = f_msg(4'd3, w_init_desc);
    else begin
      case (w_sel)
        2'd0:    w_msg = f_msg(4'd0, w_slot_desc);
        2'd1:    w_msg = f_msg(4'd1, done_desc);
        default: w_msg = f_msg(4'd2, w_fwd_desc);
      endcase
    end
  end

  assign w_in_type = ctrl_s_axis_tdata[CTRL_WIDTH-1 -: 4];
  assign w_in_acc  = ctrl_s_axis_tvalid && ctrl_s_axis_tready;
  assign w_push    = w_in_acc && (w_in_type <= 4'd1);
  assign w_pop     = rx_valid && rx_ready;
  assign w_inc     = done_ready;
  assign w_dec     = w_in_acc && (w_in_type == 4'd0) && (r_outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RESET_WAIT;
      r_ptr         <= 2'd0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_outstanding <= '0;
      r_err         <= 1'b0;
      r_rd          <= 1'b0;
      r_cnt         <= 2'd0;
    end else begin
      if (init_req) r_state <= SEND_INIT;
      else begin
        case (r_state)
          RESET_WAIT: r_state <= SEND_INIT;
          SEND_INIT:  if (w_load) r_state <= RUN;
          default:    r_state <= RUN;
        endcase
      end
      if (w_load) begin
        r_tvalid <= w_init_offer || w_grant_ok;
        if (w_init_offer || w_grant_ok) r_tdata <= w_msg;
      end
      if (w_src_acc) r_ptr <= (w_sel == 2'd2) ? 2'd0 : w_sel + 2'd1;
      if (init_req) r_outstanding <= '0;
      else if (w_inc && !w_dec) r_outstanding <= r_outstanding + SLOT_WIDTH'(1);
      else if (!w_inc && w_dec) r_outstanding <= r_outstanding - SLOT_WIDTH'(1);
      if (w_in_acc && ((w_in_type > 4'd1) || ((w_in_type == 4'd0) && (r_outstanding == '0))))
        r_err <= 1'b1;
      if (w_pop) r_rd <= ~r_rd;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_skid[r_rd ^ r_cnt[0]] <= {w_in_type[0], ctrl_s_axis_tdata[31:0]};
  end

  assign ctrl_m_axis_tdata  = r_tdata;
  assign ctrl_m_axis_tvalid = r_tvalid;
  assign ctrl_s_axis_tready = (r_cnt != 2'd2);
  assign rx_valid           = (r_cnt != 2'd0);
  assign rx_type            = r_skid[r_rd][32];
  assign rx_desc            = r_skid[r_rd][31:0];
  assign outstanding_done   = r_outstanding;
  assign ctrl_err           = r_err;

`ifdef CTRL_STATS_EN
  logic [31:0] r_tx_cnt, r_rx_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_cnt <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (r_tvalid && ctrl_m_axis_tready) r_tx_cnt <= r_tx_cnt + 32'd1;
      if (w_in_acc) r_rx_cnt <= r_rx_cnt + 32'd1;
    end
  end
  assign tx_msg_count = r_tx_cnt;
  assign rx_msg_count = r_rx_cnt;
`endif

endmodule

// File: tb/tb_core_ctrl_endpoint.sv
// tb/tb_core_ctrl_endpoint.sv - self-checking bench for core_ctrl_endpoint
module tb_core_ctrl_endpoint;
  localparam int SC = 32;
  localparam int SW = 6;
  localparam logic [35:0] FREE_MSG = 36'h0_0005_0000;
  localparam logic [35:0] DONE_MSG = 36'h1_D0E0_0001;
  localparam logic [35:0] FWD_MSG  = 36'h2_0500_ABCD;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, init_req, rx_ready;
  logic [35:0] ctrl_m_axis_tdata, ctrl_s_axis_tdata;
  logic ctrl_m_axis_tvalid, ctrl_m_axis_tready, ctrl_s_axis_tvalid, ctrl_s_axis_tready;
  logic [SW-1:0] init_slots, slot_free_data, outstanding_done;
  logic slot_free_valid, slot_free_ready, done_valid, done_ready, fwd_valid, fwd_ready;
  logic [31:0] done_desc, fwd_desc, rx_desc;
  logic rx_type, rx_valid, ctrl_err;
`ifdef CTRL_STATS_EN
  logic [31:0] tx_msg_count, rx_msg_count;
`endif

  core_ctrl_endpoint dut (
    .clk(clk), .rst(rst),
    .ctrl_m_axis_tdata(ctrl_m_axis_tdata), .ctrl_m_axis_tvalid(ctrl_m_axis_tvalid),
    .ctrl_m_axis_tready(ctrl_m_axis_tready),
    .ctrl_s_axis_tdata(ctrl_s_axis_tdata), .ctrl_s_axis_tvalid(ctrl_s_axis_tvalid),
    .ctrl_s_axis_tready(ctrl_s_axis_tready),
    .init_req(init_req), .init_slots(init_slots),
    .slot_free_data(slot_free_data), .slot_free_valid(slot_free_valid), .slot_free_ready(slot_free_ready),
    .done_desc(done_desc), .done_valid(done_valid), .done_ready(done_ready),
    .fwd_desc(fwd_desc), .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
    .rx_desc(rx_desc), .rx_type(rx_type), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .outstanding_done(outstanding_done), .ctrl_err(ctrl_err)
`ifdef CTRL_STATS_EN
    , .tx_msg_count(tx_msg_count), .rx_msg_count(rx_msg_count)
`endif
  );

  int total = 0;
  int bad = 0;
  int beats = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: message order scoreboard, skid contents, done credit count.
  bit mdl_on = 1'b0;
  int m_cnt, m_ptr;
  bit m_err;
  logic [35:0] sb_q[$];
  logic [32:0] rx_q[$];

  function automatic logic [35:0] slot_msg(input logic [SW-1:0] s);
    logic [31:0] d;
    d = 32'(s) << 16;
    return {4'h0, d};
  endfunction

  task automatic observe();
    int hs, exp_pick, idx, t;
    bit elig, found, in_acc, inc, dec;
    chk("s_tready", ctrl_s_axis_tready, rx_q.size() < 2);
    chk("rx_valid", rx_valid, rx_q.size() > 0);
    chk("ready_onehot", $countones({slot_free_ready, done_ready, fwd_ready}) <= 1, 1);
    chk("ready_wo_valid", (slot_free_ready && !slot_free_valid) || (done_ready && !done_valid)
        || (fwd_ready && !fwd_valid), 0);
    if (m_cnt == SC) chk("done_ready_full", done_ready, 0);
    if (ctrl_m_axis_tvalid && ctrl_m_axis_tready) begin
      if (ctrl_m_axis_tdata[35:32] == 4'h3) chk("init_msg", ctrl_m_axis_tdata, slot_msg(init_slots) | 36'h3_0000_0000);
      else if (sb_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_unexpected: got %0h expected none", ctrl_m_axis_tdata);
      end else chk("tx_msg", ctrl_m_axis_tdata, sb_q.pop_front());
    end
    hs = -1;
    if (slot_free_valid && slot_free_ready) hs = 0;
    if (done_valid && done_ready) hs = 1;
    if (fwd_valid && fwd_ready) hs = 2;
    if (hs >= 0) begin
      exp_pick = -1;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        elig = (idx == 0) ? slot_free_valid : (idx == 1) ? (done_valid && m_cnt < SC) : fwd_valid;
        if (elig && !found) begin exp_pick = idx; found = 1'b1; end
      end
      chk("rr_pick", hs, exp_pick);
      m_ptr = (hs + 1) % 3;
      if (hs == 0) sb_q.push_back(slot_msg(slot_free_data));
      else if (hs == 1) sb_q.push_back({4'h1, done_desc});
      else sb_q.push_back({4'h2, fwd_desc});
    end
    if (rx_valid && rx_ready && rx_q.size() > 0) chk("rx_data", {rx_type, rx_desc}, rx_q.pop_front());
    in_acc = ctrl_s_axis_tvalid && ctrl_s_axis_tready;
    t = int'(ctrl_s_axis_tdata[35:32]);
    inc = done_valid && done_ready;
    dec = in_acc && t == 0 && m_cnt > 0;
    if (in_acc && (t > 1 || (t == 0 && m_cnt == 0))) m_err = 1'b1;
    if (in_acc && t <= 1) rx_q.push_back({ctrl_s_axis_tdata[32], ctrl_s_axis_tdata[31:0]});
    if (init_req) m_cnt = 0;
    else m_cnt = m_cnt + int'(inc) - int'(dec);
  endtask

  task automatic step();
    @(negedge clk);
    if (ctrl_m_axis_tvalid && ctrl_m_axis_tready) beats++;
    if (mdl_on) observe();
    @(posedge clk);
    #1;
    if (mdl_on) begin
      chk("outstanding", outstanding_done, m_cnt);
      chk("ctrl_err", ctrl_err, m_err);
    end
  endtask

  task automatic set_src(input bit fv, input bit dv, input bit wv);
    slot_free_valid = fv;
    done_valid = dv;
    fwd_valid = wv;
  endtask

  typedef struct {
    bit fv, dv, wv;
    bit exp_v;
    logic [35:0] exp_d;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [35:0] hd;
    int b0, t;
    vecs[0]  = '{1, 1, 1, 1, FREE_MSG};
    vecs[1]  = '{1, 1, 1, 1, DONE_MSG};
    vecs[2]  = '{1, 1, 1, 1, FWD_MSG};
    vecs[3]  = '{1, 1, 1, 1, FREE_MSG};
    vecs[4]  = '{0, 0, 1, 1, FWD_MSG};
    vecs[5]  = '{0, 0, 0, 0, 36'h0};
    vecs[6]  = '{0, 1, 0, 1, DONE_MSG};
    vecs[7]  = '{1, 1, 0, 1, FREE_MSG};
    vecs[8]  = '{1, 0, 1, 1, FWD_MSG};
    vecs[9]  = '{0, 1, 1, 1, DONE_MSG};
    vecs[10] = '{1, 1, 1, 1, FWD_MSG};

    rst = 1'b1; init_req = 1'b0; init_slots = 6'd16; rx_ready = 1'b1;
    ctrl_m_axis_tready = 1'b0; ctrl_s_axis_tvalid = 1'b0; ctrl_s_axis_tdata = '0;
    slot_free_data = 6'd5; done_desc = 32'hD0E0_0001; fwd_desc = 32'h0500_ABCD;
    set_src(1, 1, 1);
    @(posedge clk); #1;
    step(); step();
    chk("rst_tvalid", ctrl_m_axis_tvalid, 0);
    chk("rst_tdata", ctrl_m_axis_tdata, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_readies", {slot_free_ready, done_ready, fwd_ready}, 0);
    chk("rst_outstanding", outstanding_done, 0);
    chk("rst_err", ctrl_err, 0);

    set_src(0, 0, 0);
    ctrl_m_axis_tready = 1'b1;
    rst = 1'b0;
    for (int n = 0; n < 10 && !ctrl_m_axis_tvalid; n++) step();
    chk("init_seen", ctrl_m_axis_tvalid, 1);
    chk("init_value", ctrl_m_axis_tdata, 36'h3_0010_0000);

    foreach (vecs[i]) begin
      set_src(vecs[i].fv, vecs[i].dv, vecs[i].wv);
      step();
      chk($sformatf("vec%0d_tvalid", i), ctrl_m_axis_tvalid, vecs[i].exp_v);
      if (vecs[i].exp_v) chk($sformatf("vec%0d_tdata", i), ctrl_m_axis_tdata, vecs[i].exp_d);
    end
    chk("cnt_after_table", outstanding_done, 3);

    // Back-pressure: the held message must not change nor let sources in.
    set_src(1, 1, 1);
    ctrl_m_axis_tready = 1'b0;
    #1;
    hd = ctrl_m_axis_tdata;
    chk("stall_value", hd, FWD_MSG);
    b0 = beats;
    for (int n = 0; n < 5; n++) begin
      chk("stall_noready", {slot_free_ready, done_ready, fwd_ready}, 0);
      step();
      chk("stall_hold", ctrl_m_axis_tdata, hd);
    end
    set_src(0, 0, 0);
    ctrl_m_axis_tready = 1'b1;
    step(); step();
    chk("stall_once", beats - b0, 1);
    chk("stall_drained", ctrl_m_axis_tvalid, 0);

    set_src(0, 1, 0);
    for (int n = 0; n < 100 && outstanding_done != 6'(SC); n++) step();
    chk("sat_count", outstanding_done, SC);
    chk("sat_done_ready", done_ready, 0);
    ctrl_s_axis_tdata = {4'h0, 32'h0000_0007};
    ctrl_s_axis_tvalid = 1'b1;
    step();
    ctrl_s_axis_tvalid = 1'b0;
    chk("credit_count", outstanding_done, SC - 1);
    chk("credit_done_ready", done_ready, 1);
    set_src(0, 0, 0);
    step();

    rx_ready = 1'b0;
    chk("err_before", ctrl_err, 0);
    ctrl_s_axis_tdata = {4'h5, 32'h1234_5678};
    ctrl_s_axis_tvalid = 1'b1;
    step();
    ctrl_s_axis_tvalid = 1'b0;
    chk("bad_type_err", ctrl_err, 1);
    chk("bad_type_dropped", rx_valid, 0);
    ctrl_s_axis_tdata = {4'h1, 32'hCAFE_F00D};
    ctrl_s_axis_tvalid = 1'b1;
    step();
    ctrl_s_axis_tvalid = 1'b0;
    chk("lb_valid", rx_valid, 1);
    chk("lb_type", rx_type, 1);
    chk("lb_desc", rx_desc, 32'hCAFE_F00D);
    rx_ready = 1'b1;
    step();

    init_slots = 6'd5;
    set_src(1, 1, 1);
    step(); step(); step();
    init_req = 1'b1;
    step();
    init_req = 1'b0;
    chk("reinit_cnt", outstanding_done, 0);
    chk("reinit_gap", ctrl_m_axis_tvalid, 0);
    for (int n = 0; n < 10 && !ctrl_m_axis_tvalid; n++) step();
    chk("reinit_msg", ctrl_m_axis_tdata, 36'h3_0005_0000);

    // Reset while an output and an incoming message are both pending.
    set_src(1, 0, 0);
    ctrl_m_axis_tready = 1'b0;
    rx_ready = 1'b0;
    ctrl_s_axis_tdata = {4'h1, 32'h0000_00AA};
    ctrl_s_axis_tvalid = 1'b1;
    step(); step();
    ctrl_s_axis_tvalid = 1'b0;
    set_src(0, 0, 0);
    rst = 1'b1;
    step();
    chk("midrst_tvalid", ctrl_m_axis_tvalid, 0);
    chk("midrst_tdata", ctrl_m_axis_tdata, 0);
    chk("midrst_rx_valid", rx_valid, 0);

    init_slots = 6'd16;
    m_cnt = 0; m_ptr = 0; m_err = 1'b0;
    sb_q.delete(); rx_q.delete();
    mdl_on = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      slot_free_valid = ($urandom_range(0, 99) < 60);
      slot_free_data = 6'($urandom_range(0, 31));
      done_valid = ($urandom_range(0, 99) < 60);
      done_desc = $urandom;
      fwd_valid = ($urandom_range(0, 99) < 50);
      fwd_desc = $urandom;
      ctrl_m_axis_tready = ($urandom_range(0, 99) < 75);
      ctrl_s_axis_tvalid = ($urandom_range(0, 99) < 50);
      t = $urandom_range(0, 99);
      t = (t < ((i < 1500) ? 10 : 45)) ? 0 : (t < 85) ? 1 : int'($urandom_range(2, 15));
      ctrl_s_axis_tdata = {t[3:0], 32'($urandom)};
      rx_ready = ($urandom_range(0, 99) < 60);
      init_req = ($urandom_range(0, 399) == 0);
      step();
    end
    mdl_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/core_ctrl_endpoint.md
CORE_CTRL_ENDPOINT -- requirements
Module: core_ctrl_endpoint

Interface
REQ-001 SHALL have parameter CTRL_WIDTH, default 36, meaning control word width: 4-bit type in [35:32] and 32-bit descriptor in [31:0].
REQ-002 SHALL have parameter SLOT_COUNT, default 32, meaning packet slots owned by this core.
REQ-003 SHALL have parameter SLOT_WIDTH, default $clog2(SLOT_COUNT+1), meaning slot number/count width.
REQ-004 SHALL have parameter CORE_ID_WIDTH, default 3, meaning destination-core field width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have ports ctrl_m_axis_tdata/tvalid/tready, output/output/input, CTRL_WIDTH/1/1, carrying messages to the load balancer.
REQ-008 SHALL have ports ctrl_s_axis_tdata/tvalid/tready, input/input/output, CTRL_WIDTH/1/1, carrying messages from the load balancer.
REQ-009 SHALL have ports init_req, input, 1, a pulse that re-announces the slot count; init_slots, input, SLOT_WIDTH, the slot count to announce.
REQ-010 SHALL have ports slot_free_data/valid/ready, input/input/output, SLOT_WIDTH/1/1, for a released slot number.
REQ-011 SHALL have ports done_desc/valid/ready, input/input/output, 32/1/1, for a packet-done descriptor.
REQ-012 SHALL have ports fwd_desc/valid/ready, input/input/output, 32/1/1, for a core-to-core descriptor with destination core in [24+:CORE_ID_WIDTH].
REQ-013 SHALL have ports rx_desc/rx_type/rx_valid/rx_ready, output/output/output/input, 32/1/1/1; rx_type 0=send-out grant, 1=loopback.
REQ-014 SHALL have ports outstanding_done, output, SLOT_WIDTH, the count of done messages not yet granted; ctrl_err, output, 1, a sticky protocol-error flag.

Function
REQ-015 SHALL format outgoing messages as: slot free = type 0, slot in [16+:SLOT_WIDTH], other bits 0; done = type 1, done_desc verbatim; forward = type 2, fwd_desc verbatim; init = type 3, init_slots in [16+:SLOT_WIDTH], other bits 0.
REQ-016 SHALL run an FSM with states RESET_WAIT, SEND_INIT and RUN; it leaves reset in RESET_WAIT and moves to SEND_INIT on the next cycle.
REQ-017 SHALL, in SEND_INIT, offer only the init message and block all source readies; it moves to RUN when the message is accepted into the output register.
REQ-018 SHALL, on an init_req pulse in any state, re-enter SEND_INIT after any in-flight output handshake and clear outstanding_done.
REQ-019 SHALL, in RUN, arbitrate slot free, done and forward round-robin with pointer order free->done->fwd; the pointer advances past the granted source only on acceptance.
REQ-020 SHALL grant a source only if its valid is high; each source ready SHALL be its grant AND the output register accepting.
REQ-021 SHALL register ctrl_m_axis outputs; the register loads when empty or when tready is high, so throughput is 1 message/cycle and latency from source handshake to tvalid is 1 cycle.
REQ-022 SHALL hold ctrl_m_axis_tdata stable while tvalid is high and tready is low.
REQ-023 SHALL increment outstanding_done on an accepted done message and decrement it on a received type-0 message.
REQ-024 SHALL leave outstanding_done unchanged on simultaneous increment and decrement; it saturates at SLOT_COUNT and does not decrement below 0.
REQ-025 SHALL block done_ready while outstanding_done equals SLOT_COUNT.
REQ-026 SHALL pass incoming type 0/1 messages through a 2-entry skid buffer to rx_*, so ctrl_s_axis_tready is high whenever the buffer is not full.
REQ-027 SHALL accept and drop incoming messages of type 2..15, setting ctrl_err; a type-0 message received with outstanding_done at 0 SHALL also set ctrl_err.
REQ-028 SHALL clear ctrl_err only by reset.

Reset
REQ-029 SHALL on rst: ctrl_m_axis_tvalid=0, tdata=0, rx_valid=0, all source readies=0, outstanding_done=0, ctrl_err=0, arbitration pointer=free, FSM=RESET_WAIT.
REQ-030 SHALL let rst asserted mid-handshake discard the pending output and skid contents without emitting a partial message.

Configuration
REQ-031 SHALL compile, when CTRL_STATS_EN is defined, 32-bit wrapping outputs tx_msg_count and rx_msg_count that count accepted outgoing and incoming messages and are reset to 0.
REQ-032 SHALL omit both ports and counters when CTRL_STATS_EN is undefined, with all other behaviour identical.

Verification
REQ-033 SHALL test reset release with init_slots=16: first output is 0x3_0010_0000, then sources enabled.
REQ-034 SHALL test free/done/fwd all valid with tready=1: the order is type0, type1, type2, repeating, at 1 message/cycle.
REQ-035 SHALL test tready held low 5 cycles with a message pending: tdata is stable, no source is accepted, and the message appears once after release.
REQ-036 SHALL test 32 done messages with no grant: done_ready drops and outstanding_done=32; one type-0 in brings it to 31 with done_ready high.
REQ-037 SHALL test an incoming type-5 message: it is dropped, ctrl_err=1 and rx_valid stays 0; an incoming type-1 gives rx_type=1 with the descriptor intact.
REQ-038 SHALL test init_req mid-stream: the next accepted output is type 3 and outstanding_done=0.
